banked_ram_read_streamer: RTL

Sequential read engine that sits directly upstream of a banked RAM read port (LD/ST side or RD/WR side). It accepts a strided read command, issues one `read_req`/`read_addr` per cycle to the RAM, absorbs the RAM's 1-cycle registered read latency in a small skid FIFO, and presents the data as a valid/ready stream with a `last` marker. Downstream consumers such as PE-array feeders and the store path stall it through `m_ready` and never lose a word.

---
 rtl/banked_ram_read_streamer_pkg.sv | 17 +
 rtl/stream_skid_fifo.sv | 73 +++++++
 rtl/banked_ram_read_streamer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/banked_ram_read_streamer_pkg.sv
// Shared definitions for the banked RAM read streamer.
// Holds the streamer FSM state type and the default word/address/count
// widths, which are also used when instantiating the banked RAM itself.
package banked_ram_read_streamer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 13;
    localparam int DEF_COUNT_W    = 16;
    localparam int DEF_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO that absorbs the RAM read latency in front of the
// output stream. The head entry comes straight out of the storage registers,
// so data_out is glitch-free and holds steady while nothing is popped.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, data_in  : write one word
//   pop            : remove the head word
//   data_out       : current head word
//   count          : number of stored words
//   empty, full    : occupancy flags
module stream_skid_fifo
    import banked_ram_read_streamer_pkg::*;
#(
    parameter  int WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH = DEF_SKID_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap explicitly so non power-of-two depths also work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            assert (!(pop && empty));
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/banked_ram_read_streamer.sv
// Strided read engine in front of a banked RAM read port.
// Takes a (base, stride, count) command, issues one RAM read per cycle while
// skid-FIFO credit allows, captures the data one cycle later and presents it
// as a valid/ready stream with a last marker and a done pulse.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cfg_valid/cfg_ready            : command handshake (ready only in IDLE)
//   cfg_base_addr/stride/count     : command fields
//   mem_read_req/addr/data         : RAM read port, data one cycle after req
//   m_valid/m_ready/m_data/m_last  : output stream
//   done                           : one-cycle pulse after the command ends
module banked_ram_read_streamer
    import banked_ram_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [COUNT_W-1:0]    cfg_count,
    output logic                  mem_read_req,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done
);

    localparam int FCNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W  = FCNT_W + 1;

    stream_state_t state;
    stream_state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    issued_q;
    logic [COUNT_W-1:0]    accepted_q;
    logic                  inflight_q;
    logic                  done_q;

    logic                  start_cmd;
    logic                  done_next;
    logic                  pop;
    logic [OCC_W-1:0]      occupancy;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Words already held plus the one still coming back from the RAM, minus
    // the word leaving this cycle, must leave room for one more request.
    assign pop          = m_valid && m_ready;
    assign occupancy    = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign mem_read_req = (state == ST_STREAM) && (occupancy < OCC_W'(SKID_DEPTH));
    assign mem_read_addr = addr_q;

    assign m_valid = !fifo_empty;
    assign m_last  = m_valid && (accepted_q == count_q - COUNT_W'(1));
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length command is acknowledged in IDLE and only produces done.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        start_cmd  = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_count != '0) begin
                        start_cmd  = 1'b1;
                        state_next = ST_STREAM;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (mem_read_req && (issued_q + COUNT_W'(1) == count_q)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address is an accumulator, so wrap-around falls out of the adder width.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            stride_q   <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            assert (!(inflight_q && fifo_full && !pop));
            inflight_q <= mem_read_req;
            done_q     <= done_next;
            if (start_cmd) begin
                addr_q     <= cfg_base_addr;
                stride_q   <= cfg_stride;
                count_q    <= cfg_count;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (mem_read_req) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + COUNT_W'(1);
                end
                if (pop) begin
                    accepted_q <= accepted_q + COUNT_W'(1);
                end
            end
        end
    end

    // RAM data is only meaningful the cycle after a request, so capture is
    // gated by the registered request rather than taken every cycle.
    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_q),
        .pop      (pop),
        .data_in  (mem_read_data),
        .data_out (m_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule
